// File: rtl/upipe_ctrl.sv
// Microprogram pipeline controller: owns the pipeline register between the
// control store and an am2910-style sequencer, inserting NOPs while fetches stall.
module upipe_ctrl (
  input  logic        clk,
  input  logic        nRESET,
  input  logic [11:0] Y,
  input  logic        nPL,
  input  logic        nMAP,
  input  logic        nVECT,
  input  logic [11:0] map_addr,
  input  logic [11:0] vect_addr,
  input  logic [7:0]  cond,
  input  logic        halt,
  output logic [11:0] cs_addr,
  output logic        cs_req,
  input  logic        cs_ack,
  input  logic [31:0] cs_data,
  output logic [3:0]  I,
  output logic        nCCEN,
  output logic        nRLD,
  output logic        CI,
  output logic        nCC,
  output logic [11:0] D,
  output logic [8:0]  uf,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // JZ: I=0000 with nCCEN/nRLD/CI high. NOP: I=0011 (CJP, condition disabled
  // so it always jumps to its own branch field, re-presenting the stalled address).
  localparam logic [31:0] JZ_WORD  = 32'h0000_0610;
  localparam logic [31:0] NOP_BASE = 32'h0000_0613;

  logic [1:0]  state, state_nxt;
  logic [11:0] pend_addr, pend_nxt;
  logic [31:0] pr, pr_nxt;
  logic [15:0] stall_nxt;
  logic        load_nop;

  // Fetch handshake: cs_addr is always Y; a fetch completes in any cycle where
  // cs_req and cs_ack are both high, and cs_data is consumed in that same cycle.
  // An ack without req (HOLD, or halt asserted) is ignored.
  assign cs_addr = Y;
  assign cs_req  = (state != ST_HOLD) && !halt;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_addr;
    pr_nxt    = pr;
    load_nop  = 1'b0;
    case (state)
      ST_RUN, ST_WAIT: begin
        if (halt) begin
          pend_nxt  = Y;
          load_nop  = 1'b1;
          state_nxt = ST_HOLD;
        end else if (cs_ack) begin
          pr_nxt    = cs_data;
          state_nxt = ST_RUN;
        end else begin
          if (state == ST_RUN) pend_nxt = Y;
          load_nop  = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (halt) load_nop = 1'b1;
        else      state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_RUN;
    endcase
    if (load_nop) pr_nxt = NOP_BASE | {9'd0, pend_nxt, 11'd0};
  end

  assign stall_nxt = (load_nop && (stall_cnt != 16'hFFFF)) ? stall_cnt + 16'd1 : stall_cnt;

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state     <= ST_RUN;
      pend_addr <= 12'd0;
      pr        <= JZ_WORD;
      stall_cnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_nxt;
      pr        <= pr_nxt;
      stall_cnt <= stall_nxt;
    end
  end

  assign I         = pr[3:0];
  assign nCCEN     = pr[4];
  assign nRLD      = pr[9];
  assign CI        = pr[10];
  assign uf        = pr[31:23];
  assign nCC       = ~(cond[pr[7:5]] ^ pr[8]);
  assign state_dbg = state;

  always_comb begin
    if (!nMAP)       D = map_addr;
    else if (!nVECT) D = vect_addr;
    else if (!nPL)   D = pr[22:11];
    else             D = 12'h000;
  end

endmodule

// File: doc/upipe_ctrl.md
UPIPE_CTRL -- requirements
Module: upipe_ctrl

Interface
REQ-001 Ports: one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock, shared with the am2910 sequencer.
REQ-003 nRESET  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 Y  input  12  next-microaddress from the sequencer.
REQ-005 nPL, nMAP, nVECT  input  1 each  sequencer source enables for D.
REQ-006 map_addr, vect_addr  input  12 each  mapping-PROM and interrupt-vector addresses.
REQ-007 cond  input  8  datapath condition flags.
REQ-008 halt  input  1  when high, no new fetch is issued and the sequencer is frozen.
REQ-009 cs_addr  output  12  control-store address.
REQ-010 cs_req  output  1  fetch request.
REQ-011 cs_ack  input  1  fetch complete; cs_data is valid in the same cycle.
REQ-012 cs_data  input  32  microword: [3:0] I, [4] nCCEN, [7:5] cc_sel, [8] cc_pol, [9] nRLD, [10] CI, [22:11] branch, [31:23] uf.
REQ-013 I  output  4  registered sequencer instruction.
REQ-014 nCCEN, nRLD, CI  output  1 each  registered sequencer controls.
REQ-015 nCC  output  1  condition to sequencer.
REQ-016 D  output  12  sequencer data input.
REQ-017 uf  output  9  registered datapath field.
REQ-018 stall_cnt  output  16  wait-cycle counter.

Function
REQ-019 The pipeline register (PR) SHALL hold all 32 microword bits; every registered output SHALL come from the PR.
REQ-020 A NOP word SHALL be defined as: I=4'b0011, nCCEN=1, nRLD=1, CI=1, uf=0, branch=pend_addr, cc_sel=0, cc_pol=0; it re-presents pend_addr on Y with no stack, counter or uPC side effects.
REQ-021 FSM states: RUN, WAIT, HOLD.
REQ-022 cs_addr SHALL equal Y combinationally in all states; cs_req SHALL be 1 in RUN and WAIT when halt=0, and 0 otherwise.
REQ-023 RUN, halt=0, cs_ack=1: PR <= cs_data at the next edge; stay in RUN.
REQ-024 RUN, halt=0, cs_ack=0: pend_addr <= Y; PR <= NOP; go to WAIT.
REQ-025 WAIT, cs_ack=1: PR <= cs_data; go to RUN. WAIT, cs_ack=0: PR <= NOP; stay in WAIT.
REQ-026 RUN or WAIT with halt=1: pend_addr <= Y; PR <= NOP; go to HOLD. An ack arriving in that cycle SHALL be ignored.
REQ-027 HOLD, halt=1: PR <= NOP; stay in HOLD. HOLD, halt=0: go to WAIT without loading PR, so the re-presented address is refetched.
REQ-028 D selection, by priority: nMAP=0 -> map_addr; nVECT=0 -> vect_addr; nPL=0 -> PR.branch; otherwise 12'h000.
REQ-029 nCC SHALL equal ~(cond[PR.cc_sel] ^ PR.cc_pol), combinationally.
REQ-030 stall_cnt SHALL increment by 1 on every edge at which PR <= NOP is loaded (states WAIT and HOLD included), and SHALL saturate at 16'hFFFF.
REQ-031 Fetch latency with a zero-wait store SHALL be 0 cycles: one microinstruction per clock.
REQ-032 Each N-cycle ack delay SHALL insert exactly N NOP words.

Reset
REQ-033 nRESET=0 at an edge: state <= RUN; pend_addr <= 0; stall_cnt <= 0; PR <= JZ word.
REQ-034 JZ word: I=4'b0000, nCCEN=1, nRLD=1, CI=1, branch=0, cc_sel=0, cc_pol=0, uf=0.
REQ-035 Reset SHALL override halt and cs_ack; reset asserted during WAIT or HOLD SHALL discard the pending fetch.
REQ-036 On the first cycle after reset the sequencer clears, so Y=0 and a fetch of address 0 is issued.

Verification
REQ-037 Reset then zero-wait store: after release, fetch addresses are 0, 1, 2, ...; I follows the stored words with no NOP.
REQ-038 Ack delayed 3 cycles at address 12'h005: exactly 3 NOPs with D=12'h005; PR then loads the word at 005; stall_cnt=3.
REQ-039 halt pulsed for 2 cycles at Y=12'h010: NOPs with D=12'h010; after release, exactly one WAIT cycle, then the word at 010 loads; an ack during the halt cycle is ignored.
REQ-040 PR.I=0010 with map_addr=12'hABC: D=12'hABC. PR.I=0110 with vect_addr=12'h123: D=12'h123.
REQ-041 cc_sel=5, cc_pol=1, cond[5]=1: nCC=1. cc_pol=0, cond[5]=1: nCC=0.
REQ-042 Force 70000 stall cycles: stall_cnt holds at 16'hFFFF; nRESET=0 in WAIT -> next I=4'b0000 and stall_cnt=0.
